// File: rtl/merge_sched.sv
// Round-robin scheduler for a shared two-operand merge unit with a fast and a slow path.
// Optional build macro MERGE_SCHED_KILL_EN: a set bit W-2 in a captured operand forces a zero result.
module merge_sched #(
  parameter int W        = 32,
  parameter int SLOW_LAT = 4,
  parameter int CNT_W    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_opa,
  input  logic [W-1:0] req0_opb,
  input  logic         req0_fast,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_opa,
  input  logic [W-1:0] req1_opb,
  input  logic         req1_fast,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     opa_r, opb_r;
  logic             fast_r, id_r;

  logic             gnt, accept;
  logic [W-1:0]     g_opa, g_opb;
  logic             g_fast;

  function automatic logic [W-1:0] merge_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic f);
    logic [W-1:0] r;
    r = f ? (a + b) : a;
`ifdef MERGE_SCHED_KILL_EN
    if (a[W-2] | b[W-2]) r = '0;
`endif
    return r;
  endfunction

  // Grant is only meaningful while idle; with both requesting, rr_ptr breaks the tie.
  always_comb begin
    gnt    = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    accept = (state == IDLE) & (req0_valid | req1_valid);
    g_opa  = gnt ? req1_opa  : req0_opa;
    g_opb  = gnt ? req1_opb  : req0_opb;
    g_fast = gnt ? req1_fast : req0_fast;
  end

  assign req0_ready = accept & ~gnt;
  assign req1_ready = accept & gnt;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (accept) begin
      opa_r  <= g_opa;
      opb_r  <= g_opb;
      fast_r <= g_fast;
      id_r   <= gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= ~gnt;
            if (g_fast) begin
              // Fast result is formed from the same values being captured this edge.
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_id    <= gnt;
              resp_data  <= merge_result(g_opa, g_opb, 1'b1);
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(SLOW_LAT - 2);
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_id    <= id_r;
            resp_data  <= merge_result(opa_r, opb_r, fast_r);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_sched.sv
// Bench for merge_sched: vector table plus scoreboard-checked responses and corner sequences.
module tb_merge_sched;
  localparam int W        = 32;
  localparam int SLOW_LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_fast;
  logic [W-1:0] req0_opa, req0_opb;
  logic         req1_valid, req1_ready, req1_fast;
  logic [W-1:0] req1_opa, req1_opb;
  logic         resp_valid, resp_ready, resp_id, busy;
  logic [W-1:0] resp_data;

  merge_sched #(.W(W), .SLOW_LAT(SLOW_LAT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa),
    .req0_opb(req0_opb), .req0_fast(req0_fast),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa),
    .req1_opb(req1_opb), .req1_fast(req1_fast),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        fast;
    int          stall;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          acc;
    logic        fast;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          hold     = 0;
  logic        seen, taken_prev;
  logic        pid;
  logic [31:0] pdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Consumer: holds resp_ready low for 'hold' cycles of a pending response.
  always @(posedge clk) begin
    #1;
    if (resp_valid && hold > 0) begin
      resp_ready = 1'b0;
      hold--;
    end else begin
      resp_ready = 1'b1;
    end
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      seen       = 1'b0;
      taken_prev = 1'b0;
    end else begin
      if (taken_prev) begin
        chk("idle_after_take_busy", {31'b0, busy}, 32'd0);
        chk("idle_after_take_valid", {31'b0, resp_valid}, 32'd0);
      end
      taken_prev = 1'b0;
      if (req0_valid && req1_valid)
        chk("single_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_resp", {31'b0, resp_valid}, 32'd0);
        end else begin
          if (!seen) begin
            chk("latency", cyc - q[0].acc, q[0].fast ? 32'd1 : SLOW_LAT);
            seen = 1'b1;
          end else begin
            chk("hold_id", {31'b0, resp_id}, {31'b0, pid});
            chk("hold_data", resp_data, pdata);
          end
          chk("busy_in_done", {31'b0, busy}, 32'd1);
          if (resp_ready) begin
            chk("resp_id", {31'b0, resp_id}, {31'b0, q[0].id});
            chk("resp_data", resp_data, q[0].data);
            void'(q.pop_front());
            seen       = 1'b0;
            taken_prev = 1'b1;
          end
        end
        pid   = resp_id;
        pdata = resp_data;
      end
    end
  end

  function automatic logic ready_of(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic f, input logic [31:0] exp, output int waited);
    waited = 0;
    if (id) begin req1_valid = 1'b1; req1_opa = a; req1_opb = b; req1_fast = f; end
    else    begin req0_valid = 1'b1; req0_opa = a; req0_opb = b; req0_fast = f; end
    forever begin
      @(negedge clk);
      if (ready_of(id)) break;
      waited++;
      if (waited > 50) begin
        checks++; failures++;
        $display("FAIL issue_timeout: ready never seen for id=%0d", id);
        break;
      end
      @(posedge clk); #1;
    end
    if (waited <= 50) q.push_back('{id: id, data: exp, acc: cyc, fast: f});
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (q.size() == 0) break;
      n++;
      if (n > 100) begin
        checks++; failures++;
        $display("FAIL resp_timeout: %0d responses outstanding", q.size());
        q.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    vecs[0] = '{1'b0, 32'd5,          32'd7,          1'b1, 0, 32'd12};
    vecs[1] = '{1'b1, 32'h0000_1234,  32'd0,          1'b0, 3, 32'h0000_1234};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          1'b1, 0, 32'h0000_0000};
`ifdef MERGE_SCHED_KILL_EN
    vecs[3] = '{1'b1, 32'h4000_0003,  32'd1,          1'b1, 0, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h4000_0000,  32'd9,          1'b0, 2, 32'h0000_0000};
`else
    vecs[3] = '{1'b1, 32'h4000_0003,  32'd1,          1'b1, 0, 32'h4000_0004};
    vecs[4] = '{1'b0, 32'h4000_0000,  32'd9,          1'b0, 2, 32'h4000_0000};
`endif
    vecs[5] = '{1'b1, 32'h8000_0001,  32'h8000_0001,  1'b1, 1, 32'h0000_0002};
    vecs[6] = '{1'b0, 32'h00AB_CDEF,  32'h1111_1111,  1'b0, 1, 32'h00AB_CDEF};
    vecs[7] = '{1'b1, 32'h3FFF_FFFF,  32'd1,          1'b1, 0, 32'h4000_0000};

    req0_valid = 0; req0_opa = 0; req0_opb = 0; req0_fast = 0;
    req1_valid = 0; req1_opa = 0; req1_opb = 0; req1_fast = 0;
    resp_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_id", {31'b0, resp_id}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      hold = vecs[i].stall;
      issue(vecs[i].id, vecs[i].opa, vecs[i].opb, vecs[i].fast, vecs[i].exp_data, w);
      chk("ready_same_cycle", w, 32'd0);
      wait_empty();
    end

    // Reset while a slow op is in flight: nothing may come out afterwards.
    hold = 0;
    issue(1'b1, 32'h55, 32'h0, 1'b0, 32'h55, w);
    chk("busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midop_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("midop_rst_busy", {31'b0, busy}, 32'd0);
    chk("midop_rst_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_resp", {31'b0, resp_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Contention from a freshly reset pointer: grants must alternate 0,1,0,1.
    req0_opa = 32'd10;   req0_opb = 32'd20; req0_fast = 1'b1;
    req1_opa = 32'h77;   req1_opb = 32'd3;  req1_fast = 1'b0;
    req0_valid = 1'b1;   req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      forever begin
        @(negedge clk);
        if (req0_ready || req1_ready) break;
        n++;
        if (n > 50) break;
        @(posedge clk); #1;
      end
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL grant_timeout: no grant for op %0d", k);
      end else begin
        chk("grant_order", {31'b0, req1_ready}, k % 2);
        q.push_back('{id: req1_ready, data: req1_ready ? 32'h77 : 32'd30,
                      acc: cyc, fast: ~req1_ready});
        @(posedge clk); #1;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
